// File: rtl/seq_mult_pkg.sv
// Shared types for the sequential shift-add multiplier.
// FSM state encoding lives here; operand width stays a module parameter.
package seq_mult_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

endpackage

// File: rtl/seq_mult.sv
// Radix-2 sequential multiplier, signed or unsigned operands.
// Works on magnitudes, restores the sign when C is loaded.
module seq_mult
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               CLK,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] C
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  state_t               state, state_d;
  logic [CW-1:0]        cnt, cnt_d;
  logic [2*WIDTH:0]     acc, acc_d;
  logic [WIDTH-1:0]     mcand, mcand_d;
  logic                 sign, sign_d;
  logic [2*WIDTH-1:0]   c_d;
  logic [WIDTH:0]       sum;
  logic [2*WIDTH-1:0]   prod;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    acc_d   = acc;
    mcand_d = mcand;
    sign_d  = sign;
    c_d     = C;
    sum     = acc[2*WIDTH:WIDTH]
            + (acc[0] ? {1'b0, mcand} : '0);
    prod    = acc[2*WIDTH-1:0];
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          state_d = CALC;
          cnt_d   = '0;
          // -2^(W-1) negates to itself, which is its unsigned magnitude
          mcand_d = (is_signed && A[WIDTH-1]) ? -A : A;
          acc_d   = {{(WIDTH+1){1'b0}},
                     ((is_signed && B[WIDTH-1]) ? -B : B)};
          sign_d  = is_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
        end
      end
      CALC: begin
        if (cnt == LAST) begin
          state_d = DONE;
          c_d     = sign ? -prod : prod;
        end else begin
          acc_d = {1'b0, sum, acc[WIDTH-1:1]};
          cnt_d = cnt + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      acc   <= '0;
      mcand <= '0;
      sign  <= 1'b0;
      C     <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      acc   <= acc_d;
      mcand <= mcand_d;
      sign  <= sign_d;
      C     <= c_d;
    end
  end

endmodule

// File: tb/tb_seq_mult.sv
// Scoreboard bench for seq_mult at WIDTH=32 and WIDTH=8.
// Expected products come from plain signed/unsigned arithmetic.
module tb_seq_mult;

  logic CLK = 1'b0;
  logic rst = 1'b1;
  always #5 CLK = ~CLK;

  logic        iv, ir, sg, ov, ordy;
  logic [31:0] a, b;
  logic [63:0] c;
  logic        bp_force, bp_val, bp_rnd;
  assign ordy = bp_force ? bp_val : bp_rnd;

  logic        iv8, ir8, sg8, ov8, ordy8;
  logic [7:0]  a8, b8;
  logic [15:0] c8;

  seq_mult #(.WIDTH(32)) dut (
    .CLK(CLK), .rst(rst), .in_valid(iv), .in_ready(ir),
    .A(a), .B(b), .is_signed(sg), .out_valid(ov),
    .out_ready(ordy), .C(c)
  );

  seq_mult #(.WIDTH(8)) dut8 (
    .CLK(CLK), .rst(rst), .in_valid(iv8), .in_ready(ir8),
    .A(a8), .B(b8), .is_signed(sg8), .out_valid(ov8),
    .out_ready(ordy8), .C(c8)
  );

  typedef struct {
    logic [63:0] p;
    int          acc;
  } exp_t;

  exp_t q32[$];
  exp_t q8[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge CLK) cyc <= cyc + 1;
  always @(posedge CLK) bp_rnd <= ($urandom % 4) != 0;

  task automatic chk(string name, logic [63:0] act,
                     logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic fail(string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  function automatic logic [63:0] ref32(logic [31:0] x,
                                        logic [31:0] y,
                                        logic s);
    longint sx, sy;
    if (s) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      return sx * sy;
    end
    return {32'b0, x} * {32'b0, y};
  endfunction

  function automatic logic [15:0] ref8(logic [7:0] x,
                                       logic [7:0] y,
                                       logic s);
    int sx, sy;
    if (s) begin
      sx = int'($signed(x));
      sy = int'($signed(y));
      return 16'(sx * sy);
    end
    return {8'b0, x} * {8'b0, y};
  endfunction

  function automatic logic [31:0] pick32();
    case ($urandom % 4)
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return $urandom % 16;
      default: return $urandom;
    endcase
  endfunction

  task automatic send32(logic [31:0] x, logic [31:0] y,
                        logic s);
    int n = 0;
    @(negedge CLK);
    while (!ir && n < 300) begin
      @(negedge CLK);
      n++;
    end
    if (!ir) begin
      fail("in_ready_timeout32");
      return;
    end
    a = x; b = y; sg = s; iv = 1'b1;
    q32.push_back('{ref32(x, y, s), cyc + 1});
    @(negedge CLK);
    a = $urandom; b = $urandom; sg = $urandom;
    @(negedge CLK);
    iv = 1'b0;
  endtask

  task automatic send8(logic [7:0] x, logic [7:0] y, logic s);
    int n = 0;
    @(negedge CLK);
    while (!ir8 && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (!ir8) begin
      fail("in_ready_timeout8");
      return;
    end
    a8 = x; b8 = y; sg8 = s; iv8 = 1'b1;
    q8.push_back('{{48'b0, ref8(x, y, s)}, cyc + 1});
    @(negedge CLK);
    iv8 = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q32.size() != 0 || q8.size() != 0) && n < 2000) begin
      @(negedge CLK);
      n++;
    end
    if (q32.size() != 0 || q8.size() != 0) fail("drain_timeout");
  endtask

  logic pov, hold, after_hs;
  logic [63:0] hc;
  initial begin
    pov = 0; hold = 0; after_hs = 0; hc = '0;
  end

  always @(negedge CLK) begin
    exp_t e;
    if (rst) begin
      pov = 0; hold = 0; after_hs = 0;
    end else begin
      if (after_hs) begin
        chk("hs_out_valid", {63'b0, ov}, 64'd0);
        chk("hs_in_ready", {63'b0, ir}, 64'd1);
      end
      if (hold) begin
        chk("hold_out_valid", {63'b0, ov}, 64'd1);
        chk("hold_c", c, hc);
      end
      if (ov) chk("busy_in_ready", {63'b0, ir}, 64'd0);
      if (ov && !pov) begin
        if (q32.size() == 0) fail("unexpected_out32");
        else chk("latency32", 64'(cyc - q32[0].acc), 64'd33);
      end
      if (ov && ordy && q32.size() != 0) begin
        e = q32.pop_front();
        chk("product32", c, e.p);
      end
      after_hs = ov && ordy;
      hold = ov && !ordy;
      hc = c;
      pov = ov;
    end
  end

  logic pov8;
  initial pov8 = 0;

  always @(negedge CLK) begin
    exp_t e;
    if (rst) begin
      pov8 = 0;
    end else begin
      if (ov8 && !pov8) begin
        if (q8.size() == 0) fail("unexpected_out8");
        else chk("latency8", 64'(cyc - q8[0].acc), 64'd9);
      end
      if (ov8 && q8.size() != 0) begin
        e = q8.pop_front();
        chk("product8", {48'b0, c8}, e.p);
      end
      pov8 = ov8;
    end
  end

  initial begin
    int n;
    iv = 0; a = '0; b = '0; sg = 0;
    iv8 = 0; a8 = '0; b8 = '0; sg8 = 0; ordy8 = 1'b1;
    bp_force = 1'b1; bp_val = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge CLK);
    chk("rst_in_ready", {63'b0, ir}, 64'd1);
    chk("rst_out_valid", {63'b0, ov}, 64'd0);
    chk("rst_c", c, 64'd0);
    chk("rst_c8", {48'b0, c8}, 64'd0);
    rst = 1'b0;

    send32(32'd2, 32'd2, 1'b0);
    send32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    send32(32'hFFFF_FFF8, 32'd9, 1'b1);
    send32(32'd8, 32'd9, 1'b0);
    send32(32'h8000_0000, 32'h8000_0000, 1'b1);
    drain();

    send8(8'h80, 8'h80, 1'b1);
    send8(8'h80, 8'h7F, 1'b1);
    send8(8'hFF, 8'hFF, 1'b0);
    for (int i = 0; i < 20; i++)
      send8($urandom, $urandom, $urandom);
    drain();

    @(posedge CLK); #1 bp_force = 1'b0;
    for (int i = 0; i < 40; i++)
      send32(pick32(), pick32(), $urandom);
    drain();

    @(posedge CLK); #1 bp_force = 1'b1; bp_val = 1'b0;
    send32(32'd12345, 32'd678, 1'b0);
    n = 0;
    while (!ov && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (!ov) fail("done_timeout");
    repeat (5) @(negedge CLK);
    @(posedge CLK); #1 bp_val = 1'b1;
    drain();
    repeat (2) @(negedge CLK);

    send32(32'hDEAD_BEEF, 32'h1234_5678, 1'b1);
    repeat (9) @(negedge CLK);
    rst = 1'b1;
    q32.delete();
    @(negedge CLK);
    chk("midrst_out_valid", {63'b0, ov}, 64'd0);
    chk("midrst_c", c, 64'd0);
    chk("midrst_in_ready", {63'b0, ir}, 64'd1);
    rst = 1'b0;
    send32(32'd100, 32'd100, 1'b0);
    drain();
    repeat (3) @(negedge CLK);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
